// File: rtl/rast_pipe_stall.sv
// rast_pipe_stall: stallable valid/payload register chain for rasterizer stage
// boundaries. Each stage moves forward when it is empty or when the stage in
// front of it is moving (COLLAPSE=1), or the whole chain moves together
// (COLLAPSE=0). DEPTH=0 is a plain wire-through.
module rast_pipe_stall #(
  parameter int WIDTH    = 24*9,
  parameter int DEPTH    = 2,
  parameter int COLLAPSE = 1,
  parameter int OCC_W    = (DEPTH < 2) ? 1 : $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_halt,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_halt,
  output logic [OCC_W-1:0] occupancy
);

  generate
    if (DEPTH == 0) begin : g_pass

      // No storage: everything passes straight through, halt included.
      assign out_data  = in_data;
      assign out_valid = in_valid;
      assign in_halt   = out_halt;
      assign occupancy = '0;

      // Clock and reset have nothing to act on in this configuration.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;

    end else begin : g_pipe

      logic [DEPTH-1:0] v_q;
      logic [DEPTH-1:0] v_d;
      logic [WIDTH-1:0] d_q [DEPTH];
      logic [WIDTH-1:0] d_d [DEPTH];
      logic [DEPTH:0]   en;
      logic [OCC_W-1:0] occ;

      // Stage enables, resolved from the output end back to the input.
      always_comb begin
        en        = '0;
        en[DEPTH] = !out_halt;
        for (int k = DEPTH-1; k >= 0; k--) begin
          if (COLLAPSE != 0) en[k] = !v_q[k] || en[k+1];
          else               en[k] = en[DEPTH];
        end
      end

      // Next stage contents; payload only follows a valid predecessor so
      // bubbles never overwrite data that is still in use downstream.
      always_comb begin
        v_d = v_q;
        for (int k = 0; k < DEPTH; k++) d_d[k] = d_q[k];
        if (en[0]) begin
          v_d[0] = in_valid;
          if (in_valid) d_d[0] = in_data;
        end
        for (int k = 1; k < DEPTH; k++) begin
          if (en[k]) begin
            v_d[k] = v_q[k-1];
            if (v_q[k-1]) d_d[k] = d_q[k-1];
          end
        end
      end

      // Occupancy is a popcount of the valid bits; it cannot exceed DEPTH.
      always_comb begin
        occ = '0;
        for (int k = 0; k < DEPTH; k++) occ = occ + OCC_W'(v_q[k]);
      end

      // Stage registers; reset discards everything in flight.
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= '0;
          for (int k = 0; k < DEPTH; k++) d_q[k] <= '0;
        end else begin
          v_q <= v_d;
          for (int k = 0; k < DEPTH; k++) d_q[k] <= d_d[k];
        end
      end

      assign out_data  = d_q[DEPTH-1];
      assign out_valid = v_q[DEPTH-1];
      assign in_halt   = !en[0];
      assign occupancy = occ;

    end
  endgenerate

endmodule
